// File: rtl/mfcc_pkg.sv
// mfcc_pkg: shared defaults, state types and helpers for the MFCC front end.
//   DEFAULT_*      : default widths/sizes used by the frame buffer and FFT glue
//   bank_state_t   : lifecycle of one ping-pong frame bank
//   rd_state_t     : frame buffer reader FSM states
//   bit_rev()      : reverse the low `width` bits of a value (DIT FFT input order)
package mfcc_pkg;

    localparam int unsigned DEFAULT_SAMPLE_WIDTH     = 16;
    localparam int unsigned DEFAULT_NUM_COEFFICIENTS = 400;
    localparam int unsigned DEFAULT_NFFT_SIZE        = 512;
    localparam int unsigned MAX_PTR_WIDTH            = 16;

    typedef enum logic [1:0] {
        BankEmpty,
        BankFilling,
        BankFull,
        BankStreaming
    } bank_state_t;

    typedef enum logic {
        StIdle,
        StStream
    } rd_state_t;

    // Shift-based so no variable bit index is needed; result is zero above `width`.
    function automatic logic [MAX_PTR_WIDTH-1:0] bit_rev(input logic [MAX_PTR_WIDTH-1:0] value,
                                                         input int unsigned width);
        logic [MAX_PTR_WIDTH-1:0] v;
        logic [MAX_PTR_WIDTH-1:0] r;
        v = value;
        r = '0;
        for (int unsigned i = 0; i < width; i++) begin
            r = {r[MAX_PTR_WIDTH-2:0], v[0]};
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// frame_ram: simple dual-port RAM, one write port and one synchronous read port.
//   clk            : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i   : read enable/address; rdata_o updates only when re_i is high,
//                    so it holds its value while the consumer is stalled
//   rdata_o        : registered read data
module frame_ram #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer: ping-pong frame store between the Hamming window and the FFT core.
// Captures windowed samples by frame_ptr_i into one of two banks; on frame_done_i the bank
// is streamed out as an NFFT_SIZE-word valid/ready stream, indices >= NUM_COEFFICIENTS
// reading as zero.
//   in_valid_i/frame_ptr_i/sample_i : sample write
//   frame_done_i   : end-of-frame pulse
//   frame_ready_o  : a write bank is available (registered)
//   out_valid_o/out_ready_i/out_data_o/out_index_o/out_last_o : output stream
//   overflow_o     : sticky, data or done pulse arrived with no bank available
// Build option: define FFT_BITREV_EN to emit words in bit-reversed index order.
module fft_frame_buffer
    import mfcc_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH     = DEFAULT_SAMPLE_WIDTH,
    parameter int unsigned NUM_COEFFICIENTS = DEFAULT_NUM_COEFFICIENTS,
    parameter int unsigned NFFT_SIZE        = DEFAULT_NFFT_SIZE,
    parameter int unsigned PTR_WIDTH        = $clog2(NFFT_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid_i,
    input  logic [PTR_WIDTH-1:0]           frame_ptr_i,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
    input  logic                           frame_done_i,
    output logic                           frame_ready_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic signed [SAMPLE_WIDTH-1:0] out_data_o,
    output logic [PTR_WIDTH-1:0]           out_index_o,
    output logic                           out_last_o,
    output logic                           overflow_o
);

    localparam logic [PTR_WIDTH:0] NumCoeff = (PTR_WIDTH + 1)'(NUM_COEFFICIENTS);

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];
    rd_state_t   rd_state_q, rd_state_d;
    logic        wb_q, wb_d, rb_q, rb_d;
    logic [PTR_WIDTH:0] cnt_q, cnt_d;   // words issued to the RAM read port this frame
    logic        out_valid_q, out_valid_d;
    logic [PTR_WIDTH-1:0] out_index_q, out_index_d;
    logic        out_last_q, out_last_d;
    logic        pad_q, pad_d;
    logic        out_bank_q, out_bank_d;
    logic        overflow_q, overflow_d;
    logic        frame_ready_q, frame_ready_d;

    logic                    load;
    logic                    hs;
    logic                    wr_ok;
    logic                    ptr_ok;
    logic [1:0]              ram_we;
    logic [PTR_WIDTH-1:0]    rd_addr;
    logic [SAMPLE_WIDTH-1:0] rd_data [2];

`ifdef FFT_BITREV_EN
    logic [MAX_PTR_WIDTH-1:0] rev_addr;
    assign rev_addr = bit_rev(MAX_PTR_WIDTH'(cnt_q[PTR_WIDTH-1:0]), PTR_WIDTH);
    assign rd_addr  = rev_addr[PTR_WIDTH-1:0];
`else
    assign rd_addr = cnt_q[PTR_WIDTH-1:0];
`endif

    assign hs     = out_valid_q && out_ready_i;
    assign wr_ok  = (bank_q[wb_q] == BankEmpty) || (bank_q[wb_q] == BankFilling);
    assign ptr_ok = {1'b0, frame_ptr_i} < NumCoeff;

    always_comb begin
        bank_d      = bank_q;
        rd_state_d  = rd_state_q;
        wb_d        = wb_q;
        rb_d        = rb_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        pad_d       = pad_q;
        out_bank_d  = out_bank_q;
        overflow_d  = overflow_q;
        ram_we      = 2'b00;
        load        = 1'b0;

        // Reader. Runs first so the writer sees a bank freed this cycle as EMPTY.
        unique case (rd_state_q)
            StIdle: begin
                if (bank_q[rb_q] == BankFull) begin
                    bank_d[rb_q] = BankStreaming;
                    rd_state_d   = StStream;
                    cnt_d        = '0;
                end
            end
            StStream: begin
                load = !cnt_q[PTR_WIDTH] && (!out_valid_q || out_ready_i);
                if (hs && out_last_q) begin
                    bank_d[rb_q] = BankEmpty;
                    rb_d         = !rb_q;
                    // Chain straight into a waiting bank so frames are one idle cycle apart.
                    if (bank_q[!rb_q] == BankFull) begin
                        bank_d[!rb_q] = BankStreaming;
                        cnt_d         = '0;
                    end else begin
                        rd_state_d = StIdle;
                    end
                end
            end
            default: rd_state_d = StIdle;
        endcase

        // Output register; the RAM read register is its data half.
        if (load) begin
            out_valid_d = 1'b1;
            out_index_d = rd_addr;
            out_last_d  = &cnt_q[PTR_WIDTH-1:0];
            pad_d       = {1'b0, rd_addr} >= NumCoeff;
            out_bank_d  = rb_q;
            cnt_d       = cnt_q + 1'b1;
        end else if (hs) begin
            out_valid_d = 1'b0;
        end

        // Writer.
        if (in_valid_i) begin
            if (!wr_ok) begin
                overflow_d = 1'b1;
            end else if (ptr_ok) begin
                ram_we[wb_q] = 1'b1;
                bank_d[wb_q] = BankFilling;
            end
        end
        if (frame_done_i) begin
            if (!wr_ok) begin
                overflow_d = 1'b1;
            end else begin
                bank_d[wb_q] = BankFull;
                if (bank_d[!wb_q] == BankEmpty) begin
                    wb_d = !wb_q;
                end
            end
        end

        frame_ready_d = (bank_d[wb_d] == BankEmpty) || (bank_d[wb_d] == BankFilling);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]     <= BankEmpty;
            bank_q[1]     <= BankEmpty;
            rd_state_q    <= StIdle;
            wb_q          <= 1'b0;
            rb_q          <= 1'b0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_index_q   <= '0;
            out_last_q    <= 1'b0;
            pad_q         <= 1'b0;
            out_bank_q    <= 1'b0;
            overflow_q    <= 1'b0;
            frame_ready_q <= 1'b1;
        end else begin
            bank_q        <= bank_d;
            rd_state_q    <= rd_state_d;
            wb_q          <= wb_d;
            rb_q          <= rb_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_index_q   <= out_index_d;
            out_last_q    <= out_last_d;
            pad_q         <= pad_d;
            out_bank_q    <= out_bank_d;
            overflow_q    <= overflow_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        frame_ram #(
            .WIDTH      (SAMPLE_WIDTH),
            .DEPTH      (NFFT_SIZE),
            .ADDR_WIDTH (PTR_WIDTH)
        ) u_ram (
            .clk     (clk),
            .we_i    (ram_we[b]),
            .waddr_i (frame_ptr_i),
            .wdata_i (sample_i),
            .re_i    (load),
            .raddr_i (rd_addr),
            .rdata_o (rd_data[b])
        );
    end

    // Gating on valid keeps unreset RAM read data off the port after reset.
    assign out_data_o    = (out_valid_q && !pad_q) ? rd_data[out_bank_q] : '0;
    assign out_valid_o   = out_valid_q;
    assign out_index_o   = out_index_q;
    assign out_last_o    = out_last_q;
    assign overflow_o    = overflow_q;
    assign frame_ready_o = frame_ready_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// tb_fft_frame_buffer: scoreboard bench for fft_frame_buffer. Stimulus pushes the expected
// words of each frame into a queue; a monitor pops and compares on every output handshake
// and checks that stalled outputs hold. Follows FFT_BITREV_EN for the expected order.
module tb_fft_frame_buffer;

    localparam int SW = 16;
    localparam int NC = 400;
    localparam int NF = 512;
    localparam int PW = 9;

    logic                 clk        = 1'b0;
    logic                 rst_n      = 1'b0;
    logic                 in_valid   = 1'b0;
    logic [PW-1:0]        frame_ptr  = '0;
    logic signed [SW-1:0] sample     = '0;
    logic                 frame_done = 1'b0;
    logic                 out_ready  = 1'b0;
    logic                 frame_ready;
    logic                 out_valid;
    logic signed [SW-1:0] out_data;
    logic [PW-1:0]        out_index;
    logic                 out_last;
    logic                 overflow;

    typedef struct packed {
        logic [PW-1:0] idx;
        logic [SW-1:0] data;
        logic          last;
    } word_t;

    int    total      = 0;
    int    bad        = 0;
    int    words_seen = 0;
    int    last_gap   = -1;
    int    gap        = 0;
    bit    counting   = 1'b0;
    int    rdy_mode   = 0;
    int    phase      = 0;
    bit    stall_v    = 1'b0;
    word_t held;
    word_t exp_q [$];
    logic [SW-1:0] img [NF];

    always #5 clk = ~clk;

    fft_frame_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .frame_ptr_i   (frame_ptr),
        .sample_i      (sample),
        .frame_done_i  (frame_done),
        .frame_ready_o (frame_ready),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_index_o   (out_index),
        .out_last_o    (out_last),
        .overflow_o    (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    function automatic int tb_rev(input int k);
        int r = 0;
        for (int i = 0; i < PW; i++) begin
            if ((k & (1 << i)) != 0) r = r | (1 << (PW - 1 - i));
        end
        return r;
    endfunction

    function automatic int map_addr(input int k);
`ifdef FFT_BITREV_EN
        return tb_rev(k);
`else
        return k;
`endif
    endfunction

    task automatic push_frame();
        word_t w;
        for (int k = 0; k < NF; k++) begin
            int a;
            a      = map_addr(k);
            w.idx  = PW'(a);
            w.data = (a < NC) ? img[a] : '0;
            w.last = (k == NF - 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic write_range(input int lo, input int hi, input int base, input int step);
        for (int i = lo; i <= hi; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            frame_ptr = PW'(i);
            sample    = SW'(base + step * i);
            img[i]    = SW'(base + step * i);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_done(input bit chk);
        @(posedge clk); #1;
        frame_done = 1'b1;
        @(posedge clk); #1;
        frame_done = 1'b0;
        if (chk) begin
            @(negedge clk); check("valid_after_T", 32'(out_valid), 0);
            @(negedge clk); check("valid_after_T1", 32'(out_valid), 0);
            @(negedge clk); check("valid_after_T2", 32'(out_valid), 1);
        end
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || out_valid) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d words pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_frame_ready"}, 32'(frame_ready), 1);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"}, 32'(out_data), 0);
        check({tag, "_out_index"}, 32'(out_index), 0);
        check({tag, "_out_last"}, 32'(out_last), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_idle(tag);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Ready driver: 0 = always ready, 1 = pattern 1,0,0,1, otherwise never ready.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (phase % 4 == 0) || (phase % 4 == 3);
                default: out_ready = 1'b0;
            endcase
            phase++;
        end
    end

    // Monitor / scoreboard.
    initial begin
        word_t exp_w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_v  = 1'b0;
                counting = 1'b0;
            end else begin
                if (stall_v) begin
                    check("stall_valid", 32'(out_valid), 1);
                    check("stall_hold", 32'({out_index, out_data, out_last}), 32'(held));
                end
                if (counting && out_valid) begin
                    last_gap = gap;
                    counting = 1'b0;
                end else if (counting) begin
                    gap++;
                end
                if (out_valid && out_ready) begin
                    words_seen++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_word: got index %0d, want no word", out_index);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("word_index", 32'(out_index), 32'(exp_w.idx));
                        check("word_data", 32'(out_data), 32'(exp_w.data));
                        check("word_last", 32'(out_last), 32'(exp_w.last));
                    end
                    if (out_last) begin
                        counting = 1'b1;
                        gap      = 0;
                    end
                end
                stall_v = out_valid && !out_ready;
                held    = {out_index, out_data, out_last};
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish before 400000");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single frame, sample = index, always ready.
        rdy_mode = 0;
        write_range(0, NC - 1, 0, 1);
        push_frame();
        pulse_done(1'b1);
        wait_drain(2000);

        // Back-pressure 1,0,0,1.
        rdy_mode = 1;
        write_range(0, NC - 1, 4096, 3);
        push_frame();
        pulse_done(1'b1);
        wait_drain(4000);
        check("bp_frame_ready", 32'(frame_ready), 1);
        check("bp_overflow", 32'(overflow), 0);

        // Ping-pong with the FFT stalled.
        rdy_mode = 2;
        write_range(0, NC - 1, 500, 1);
        push_frame();
        pulse_done(1'b1);
        repeat (2) @(negedge clk);
        check("pp_ready_after_f1", 32'(frame_ready), 1);
        write_range(0, NC - 1, 20000, -2);
        push_frame();
        pulse_done(1'b0);
        repeat (2) @(negedge clk);
        check("pp_ready_after_f2", 32'(frame_ready), 0);
        check("pp_overflow_before_f3", 32'(overflow), 0);
        write_range(0, 4, 9, 0);
        pulse_done(1'b0);
        @(negedge clk);
        check("pp_overflow_after_f3", 32'(overflow), 1);
        check("pp_queued", 32'(exp_q.size()), 2 * NF);
        last_gap = -1;
        rdy_mode = 0;
        wait_drain(3000);
        check("pp_gap", 32'(last_gap), 1);
        check("pp_overflow_sticky", 32'(overflow), 1);
        check("pp_ready_after_drain", 32'(frame_ready), 1);

        // Stale-data guard: two full 0x7FFF frames, then a short frame into bank 0.
        do_reset("rst2");
        for (int f = 0; f < 2; f++) begin
            write_range(0, NC - 1, 32767, 0);
            push_frame();
            pulse_done(1'b1);
            wait_drain(2000);
        end
        write_range(0, 9, 256, 1);
        push_frame();
        pulse_done(1'b1);
        wait_drain(2000);

        // Reset mid-stream at about word 100, then a clean frame from index 0.
        write_range(0, NC - 1, 1234, 1);
        push_frame();
        pulse_done(1'b0);
        start = words_seen;
        for (int c = 0; c < 2000 && (words_seen - start) < 100; c++) @(posedge clk);
        check("mid_words_reached", 32'((words_seen - start) >= 100), 1);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_idle("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        write_range(0, NC - 1, 777, 1);
        push_frame();
        pulse_done(1'b1);
        wait_drain(2000);
        check("final_frame_ready", 32'(frame_ready), 1);
        check("final_overflow", 32'(overflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
